// File: rtl/tt_um_inv_arbiter.sv
// Four requesters time-share one registered 4-bit inverter through an IDLE/EXEC/DONE FSM.
// Optional build macro INV_ARB_FIXED_PRIO_EN swaps round-robin arbitration for fixed priority (req[0] highest).
//
// state | meaning
// IDLE  | no grant; any request at the edge picks a winner
// EXEC  | winner holds gnt and drives its operand; exit edge captures ~operand
// DONE  | result valid; held until the owner drops req or the DONE timer expires

module tt_um_inv_arbiter #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

  state_t     state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [1:0] gnt_id, gnt_id_nxt;
  logic [3:0] result, result_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       tmo_flag, tmo_flag_nxt;

  logic [3:0] req;
  logic [3:0] operand;
  logic       req_owner;
  logic [1:0] win_id;
  logic [3:0] cnt_inc;
  logic       busy;
  logic       valid;
  logic [3:0] gnt;
  logic [1:0] gnt_id_out;
  logic       unused_bits;

  assign req       = ui_in[3:0];
  assign operand   = ui_in[7:4];
  assign req_owner = req[gnt_id];
  assign cnt_inc   = cnt + 4'd1;

`ifdef INV_ARB_FIXED_PRIO_EN
  assign unused_bits = ^{uio_in, ptr};

  always_comb begin
    win_id = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) win_id = 2'(i);
    end
  end
`else
  logic [1:0] idx;
  logic       found;

  assign unused_bits = ^uio_in;

  // Search starts at ptr and wraps naturally through the 2-bit index.
  always_comb begin
    win_id = 2'd0;
    idx    = 2'd0;
    found  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        win_id = idx;
        found  = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    gnt_id_nxt   = gnt_id;
    result_nxt   = result;
    cnt_nxt      = cnt;
    tmo_flag_nxt = tmo_flag;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt  = EXEC;
          gnt_id_nxt = win_id;
`ifdef INV_ARB_FIXED_PRIO_EN
          ptr_nxt    = 2'd0;
`else
          ptr_nxt    = win_id + 2'd1;
`endif
        end
      end
      EXEC: begin
        if (req_owner) begin
          state_nxt  = DONE;
          result_nxt = ~operand;
          cnt_nxt    = 4'd0;
        end else begin
          state_nxt  = IDLE;
        end
      end
      DONE: begin
        cnt_nxt = cnt_inc;
        if (!req_owner) begin
          state_nxt = IDLE;
        end else if (cnt_inc == TIMEOUT_CNT) begin
          state_nxt    = IDLE;
          tmo_flag_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      gnt_id   <= 2'd0;
      result   <= 4'd0;
      cnt      <= 4'd0;
      tmo_flag <= 1'b0;
    end else if (ena) begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      gnt_id   <= gnt_id_nxt;
      result   <= result_nxt;
      cnt      <= cnt_nxt;
      tmo_flag <= tmo_flag_nxt;
    end
  end

  // Outputs decode straight from registers so reset clears them without a clock.
  assign busy       = (state != IDLE);
  assign valid      = (state == DONE);
  assign gnt        = busy ? (4'b0001 << gnt_id) : 4'b0000;
  assign gnt_id_out = busy ? gnt_id : 2'd0;

  assign uo_out  = {gnt, result};
  assign uio_out = {3'b000, tmo_flag, gnt_id_out, busy, valid};
  assign uio_oe  = 8'h1F;

endmodule
